// File: rtl/alu_op_sequencer.sv
// Control FSM sequencing one ALU op per accepted command, owns the accumulator.
// Optional op counter enabled by defining ALU_SEQ_OPCNT_EN.
module alu_op_sequencer #(
   parameter int MULDIV_LAT = 2,
   parameter int N          = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [3:0]   cmd_op,
   input  logic [1:0]   cmd_bsrc,
   input  logic         b_is_zero,
   input  logic [N-1:0] alu_result,
   output logic [1:0]   a_s,
   output logic [3:0]   b_s,
   output logic [15:0]  op_sel,
   output logic [N-1:0] acc_out,
   output logic         busy,
   output logic         done,
   output logic         err
`ifdef ALU_SEQ_OPCNT_EN
   ,
   input  logic         op_count_clr,
   output logic [15:0]  op_count
`endif
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_EXEC = 2'd2;
   localparam logic [1:0] S_WB   = 2'd3;

   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_MUL = 4'd10;
   localparam logic [3:0] OP_DIV = 4'd11;
   localparam logic [3:0] OP_CLR = 4'd12;
   localparam logic [3:0] LAT_M1 = 4'(MULDIV_LAT - 1);

   logic [1:0]   state_q, state_d;
   logic [3:0]   op_q, op_d;
   logic [1:0]   bsrc_q, bsrc_d;
   logic [3:0]   cnt_q, cnt_d;
   logic [N-1:0] acc_q, acc_d;
   logic         err_q, err_d;
   logic         done_q, done_d;
   logic         legal, muldiv, div_zero, wr;

   assign legal  = (op_q <= OP_CLR);
   assign muldiv = (op_q == OP_MUL) || (op_q == OP_DIV);
   // DIV loads the counter with LAT_M1, so that value marks its first EXEC cycle
   assign div_zero = (op_q == OP_DIV) && b_is_zero && (cnt_q == LAT_M1);

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      bsrc_d  = bsrc_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      err_d   = err_q;
      done_d  = 1'b0;
      wr      = 1'b0;
      a_s     = 2'b01;
      b_s     = 4'b0001;
      op_sel  = '0;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               op_d    = cmd_op;
               bsrc_d  = cmd_bsrc;
               err_d   = 1'b0;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            a_s = 2'b10;
            case (bsrc_q)
               2'd0:    b_s = 4'b0100;
               2'd1:    b_s = 4'b0010;
               2'd2:    b_s = 4'b1000;
               default: b_s = 4'b0001;
            endcase
            cnt_d   = muldiv ? LAT_M1 : 4'd0;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            if (legal) op_sel = 16'd1 << op_q;
            if (!legal || div_zero) begin
               err_d   = 1'b1;
               state_d = S_WB;
            end else if (cnt_q == 4'd0) begin
               state_d = S_WB;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            wr = !err_q && legal && (op_q != OP_NOP);
            if (wr) acc_d = (op_q == OP_CLR) ? '0 : alu_result;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         bsrc_q  <= '0;
         cnt_q   <= '0;
         acc_q   <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         bsrc_q  <= bsrc_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign cmd_ready = ~busy;
   assign acc_out   = acc_q;
   assign done      = done_q;
   assign err       = err_q;

`ifdef ALU_SEQ_OPCNT_EN
   logic [15:0] op_count_q, op_count_d;

   always_comb begin
      op_count_d = op_count_q;
      if (op_count_clr) op_count_d = '0;
      else if (wr)      op_count_d = op_count_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) op_count_q <= '0;
      else     op_count_q <= op_count_d;
   end

   assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: datapath stand-in, timeline model, directed ops.
module tb_alu_op_sequencer;

   localparam int LAT = 2;
   localparam int N   = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [3:0]   cmd_op;
   logic [1:0]   cmd_bsrc;
   logic         b_is_zero;
   logic [N-1:0] alu_result;
   logic [1:0]   a_s;
   logic [3:0]   b_s;
   logic [15:0]  op_sel;
   logic [N-1:0] acc_out;
   logic         busy, done, err;
`ifdef ALU_SEQ_OPCNT_EN
   logic         op_count_clr;
   logic [15:0]  op_count;
`endif

   alu_op_sequencer #(.MULDIV_LAT(LAT), .N(N)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_bsrc(cmd_bsrc), .b_is_zero(b_is_zero),
      .alu_result(alu_result), .a_s(a_s), .b_s(b_s), .op_sel(op_sel),
      .acc_out(acc_out), .busy(busy), .done(done), .err(err)
`ifdef ALU_SEQ_OPCNT_EN
      , .op_count_clr(op_count_clr), .op_count(op_count)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [N-1:0] fu(input logic [3:0] op,
                                       input logic [N-1:0] a,
                                       input logic [N-1:0] b);
      case (op)
         4'd1:    fu = a + b;
         4'd2:    fu = a & b;
         4'd3:    fu = ~(a & b);
         4'd4:    fu = a | b;
         4'd5:    fu = ~(a | b);
         4'd6:    fu = a ^ b;
         4'd7:    fu = ~(a ^ b);
         4'd8:    fu = a << b[3:0];
         4'd9:    fu = a >> b[3:0];
         4'd10:   fu = a * b;
         4'd11:   fu = (b == '0) ? '0 : a / b;
         default: fu = '0;
      endcase
   endfunction

   // input-register stage and function units driven by the DUT selects
   logic [N-1:0] a_in, b_in, env_a, env_b;
   logic [15:0]  env_sel, sel;
   logic [3:0]   sel_idx;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         env_a   <= '0;
         env_b   <= '0;
         env_sel <= '0;
      end else begin
         if (a_s == 2'b10) env_a <= a_in;
         case (b_s)
            4'b1000: env_b <= '0;
            4'b0100: env_b <= b_in;
            4'b0010: env_b <= acc_out;
            default: ;
         endcase
         if (op_sel != '0) env_sel <= op_sel;
      end
   end

   always_comb begin
      sel     = (op_sel != '0) ? op_sel : env_sel;
      sel_idx = '0;
      for (int i = 0; i < 16; i++) if (sel[i]) sel_idx = 4'(i);
      alu_result = fu(sel_idx, env_a, env_b);
   end
   assign b_is_zero = (env_b == '0);

   // model: m_k counts cycles since acceptance, 0 when idle
   int           m_k, m_len;
   logic [3:0]   m_op;
   logic [1:0]   m_bsrc;
   logic [N-1:0] m_a, m_b, m_acc;
   logic         m_err, m_done, m_bad;
   logic [15:0]  m_cnt;
   int           checks = 0;
   int           errors = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] bmap(input logic [1:0] s);
      case (s)
         2'd0:    bmap = 4'b0100;
         2'd1:    bmap = 4'b0010;
         2'd2:    bmap = 4'b1000;
         default: bmap = 4'b0001;
      endcase
   endfunction

   task automatic model_reset();
      m_k = 0; m_len = 1; m_op = '0; m_bsrc = '0; m_a = '0; m_b = '0;
      m_acc = '0; m_err = 1'b0; m_done = 1'b0; m_bad = 1'b0; m_cnt = '0;
   endtask

   task automatic model_edge();
      logic clr;
`ifdef ALU_SEQ_OPCNT_EN
      clr = op_count_clr;
`else
      clr = 1'b0;
`endif
      if (rst) begin
         model_reset();
         return;
      end
      m_done = 1'b0;
      if (clr) m_cnt = '0;
      if (m_k == 0) begin
         if (cmd_valid) begin
            m_op = cmd_op; m_bsrc = cmd_bsrc; m_err = 1'b0; m_k = 1;
         end
      end else if (m_k == 1) begin
         m_a = a_in;
         case (m_bsrc)
            2'd0:    m_b = b_in;
            2'd1:    m_b = m_acc;
            2'd2:    m_b = '0;
            default: ;
         endcase
         m_bad = (m_op > 4'd12) || (m_op == 4'd11 && m_b == '0);
         m_len = (!m_bad && (m_op == 4'd10 || m_op == 4'd11)) ? LAT : 1;
         m_k = 2;
      end else if (m_k < 2 + m_len) begin
         if (m_k == 2 && m_bad) m_err = 1'b1;
         m_k++;
      end else begin
         if (!m_bad && m_op != 4'd0) begin
            m_acc = (m_op == 4'd12) ? '0 : fu(m_op, m_a, m_b);
            if (!clr) m_cnt = m_cnt + 16'd1;
         end
         m_done = 1'b1;
         m_k = 0;
      end
   endtask

   task automatic check_all(input string tag);
      logic        ex_exec;
      logic [15:0] ex_sel;
      ex_exec = (m_k >= 2) && (m_k <= 1 + m_len);
      ex_sel  = (ex_exec && m_op <= 4'd12) ? (16'd1 << m_op) : 16'd0;
      chk({tag, ".ready"}, 32'(cmd_ready), 32'(m_k == 0));
      chk({tag, ".busy"}, 32'(busy), 32'(m_k != 0));
      chk({tag, ".done"}, 32'(done), 32'(m_done));
      chk({tag, ".a_s"}, 32'(a_s), (m_k == 1) ? 32'h2 : 32'h1);
      chk({tag, ".b_s"}, 32'(b_s), (m_k == 1) ? 32'(bmap(m_bsrc)) : 32'h1);
      chk({tag, ".op_sel"}, 32'(op_sel), 32'(ex_sel));
      chk({tag, ".acc"}, 32'(acc_out), 32'(m_acc));
      chk({tag, ".err"}, 32'(err), 32'(m_err));
`ifdef ALU_SEQ_OPCNT_EN
      chk({tag, ".op_count"}, 32'(op_count), 32'(m_cnt));
`endif
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all("cyc");
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (m_k != 0 && n < 40) begin
         step();
         n++;
      end
      chk("idle_timeout", 32'(m_k), 32'd0);
   endtask

   task automatic issue(input logic [3:0] op, input logic [1:0] bs,
                        input logic [N-1:0] a, input logic [N-1:0] b);
      logic was_idle;
      int   n;
      cmd_valid = 1'b1; cmd_op = op; cmd_bsrc = bs; a_in = a; b_in = b;
      n = 0;
      do begin
         was_idle = (m_k == 0);
         step();
         n++;
      end while (!was_idle && n < 40);
      cmd_valid = 1'b0;
      wait_idle();
   endtask

   logic [3:0]   t_op   [12] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                                  4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd0};
   logic [1:0]   t_bs   [12] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0,
                                  2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
   logic [N-1:0] t_a    [12] = '{16'hF0F0, 16'hFF00, 16'h0101, 16'h00FF,
                                  16'h1234, 16'hAAAA, 16'h8001, 16'h8001,
                                  16'h1234, 16'd100, 16'd0, 16'd5};
   logic [N-1:0] t_b    [12] = '{16'h3C3C, 16'h0FF0, 16'd0, 16'd0,
                                  16'd0, 16'h5555, 16'd4, 16'd15,
                                  16'h0100, 16'd7, 16'd0, 16'd5};

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_bsrc = '0;
      a_in = '0; b_in = '0;
`ifdef ALU_SEQ_OPCNT_EN
      op_count_clr = 1'b0;
`endif
      model_reset();
      @(negedge clk);
      @(negedge clk);
      chk("rst.ready", 32'(cmd_ready), 32'd1);
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.acc", 32'(acc_out), 32'd0);
      chk("rst.a_s", 32'(a_s), 32'h1);
      chk("rst.b_s", 32'(b_s), 32'h1);
      chk("rst.op_sel", 32'(op_sel), 32'd0);
      check_all("rst");
      rst = 1'b0;
      step();

      cmd_valid = 1'b1; cmd_op = 4'd1; cmd_bsrc = 2'd0; a_in = 16'd5; b_in = 16'd7;
      step();
      cmd_valid = 1'b0;
      chk("add.load_a_s", 32'(a_s), 32'h2);
      chk("add.load_b_s", 32'(b_s), 32'h4);
      step();
      chk("add.op_sel", 32'(op_sel), 32'h0002);
      step();
      chk("add.wb_ready", 32'(cmd_ready), 32'd0);
      step();
      chk("add.done", 32'(done), 32'd1);
      chk("add.acc", 32'(acc_out), 32'd12);

      issue(4'd10, 2'd1, 16'd3, 16'd0);
      chk("mul.acc", 32'(acc_out), 32'd36);

      issue(4'd11, 2'd2, 16'd9, 16'd4);
      chk("divz.err", 32'(err), 32'd1);
      chk("divz.acc", 32'(acc_out), 32'd36);
      issue(4'd1, 2'd0, 16'd1, 16'd2);
      chk("divz.clr_err", 32'(err), 32'd0);
      chk("divz.acc2", 32'(acc_out), 32'd3);

      cmd_valid = 1'b1; cmd_op = 4'd14; cmd_bsrc = 2'd0;
      step();
      step();
      chk("ill.op_sel", 32'(op_sel), 32'd0);
      cmd_op = 4'd6; a_in = 16'h00F0; b_in = 16'h0FF0;
      step();
      chk("ill.err", 32'(err), 32'd1);
      chk("ill.held_ready", 32'(cmd_ready), 32'd0);
      issue(4'd6, 2'd0, 16'h00F0, 16'h0FF0);
      chk("ill.next_acc", 32'(acc_out), 32'h0F00);

      for (int i = 0; i < 12; i++) issue(t_op[i], t_bs[i], t_a[i], t_b[i]);
      issue(4'd11, 2'd0, 16'd100, 16'd7);
      chk("div.acc", 32'(acc_out), 32'd14);

      cmd_valid = 1'b1; cmd_op = 4'd10; cmd_bsrc = 2'd0; a_in = 16'd7; b_in = 16'd9;
      step();
      cmd_valid = 1'b0;
      step();
      @(posedge clk);
      model_edge();
      #2 rst = 1'b1;
      #1 model_reset();
      chk("mrst.busy", 32'(busy), 32'd0);
      chk("mrst.acc", 32'(acc_out), 32'd0);
      check_all("mrst");
      @(negedge clk);
      check_all("mrst_hold");
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("mrst.no_done", 32'(done), 32'd0);
      end

`ifdef ALU_SEQ_OPCNT_EN
      issue(4'd1, 2'd0, 16'd1, 16'd1);
      issue(4'd2, 2'd0, 16'd3, 16'd1);
      issue(4'd15, 2'd0, 16'd3, 16'd1);
      issue(4'd4, 2'd0, 16'd3, 16'd4);
      chk("cnt.three", 32'(op_count), 32'd3);
      cmd_valid = 1'b1; cmd_op = 4'd1; cmd_bsrc = 2'd0;
      step();
      cmd_valid = 1'b0;
      step();
      step();
      op_count_clr = 1'b1;
      step();
      op_count_clr = 1'b0;
      chk("cnt.clr_wb", 32'(op_count), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
